// File: rtl/game_pkg.sv
// Shared game definitions: FSM encoding, play-field limits and coordinate width.
package game_pkg;

  localparam int COORD_W = 10;

  // Play-field limits in pixels.
  localparam int Y_TOP = 30;
  localparam int X_MIN = 150;
  localparam int X_MAX = 800;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLYING   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV counter that emits a one-cycle tick on its last count while enabled.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count 0..DIV-1 while enabled; a clear restarts the period from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tank_bullet.sv
// Player tank projectile: launches from the tank on a fire edge, climbs one
// pixel every STEP_DIV cycles and retires at the top row or on a monster hit.
module tank_bullet #(
  parameter int STEP_DIV     = 4,
  parameter int Y_TOP        = game_pkg::Y_TOP,
  parameter int COOLDOWN_CYC = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         up,
  input  logic [game_pkg::COORD_W-1:0] xpos_tank,
  input  logic [game_pkg::COORD_W-1:0] ypos_tank,
  input  logic                         hit,
  output logic [game_pkg::COORD_W-1:0] xpos_bullet,
  output logic [game_pkg::COORD_W-1:0] ypos_bullet,
  output logic                         bullet_active,
  output logic                         bullet_hit,
  output logic                         bullet_done
);

  import game_pkg::*;

  localparam int CD_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic [CD_W-1:0]    CD_LAST = CD_W'(COOLDOWN_CYC - 1);
  localparam logic [COORD_W-1:0] Y_LIM   = COORD_W'(Y_TOP);

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   xpos_q, xpos_d;
  logic [COORD_W-1:0]   ypos_q, ypos_d;
  logic                 active_q, active_d;
  logic                 hit_q, hit_d;
  logic                 done_q, done_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 up_q;
  logic                 fire;
  logic                 step_tick;
  logic                 step_clr;

  // A button already held when it was last sampled is not a new shot.
  assign fire = up & ~up_q;

  tick_gen #(
    .DIV (STEP_DIV)
  ) u_step (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_FLYING),
    .clr  (step_clr),
    .tick (step_tick)
  );

  // Next-state and next-output logic for the bullet life cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    active_d = active_q;
    hit_d    = 1'b0;
    done_d   = 1'b0;
    cd_d     = cd_q;
    step_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          xpos_d   = xpos_tank;
          ypos_d   = ypos_tank;
          active_d = 1'b1;
          step_clr = 1'b1;
          state_d  = ST_FLYING;
        end
      end

      ST_FLYING: begin
        // A hit outranks both the climb step and top-row retirement.
        if (hit) begin
          hit_d    = 1'b1;
          active_d = 1'b0;
          cd_d     = '0;
          state_d  = ST_COOLDOWN;
        end else if (step_tick) begin
          if (ypos_q <= Y_LIM) begin
            done_d   = 1'b1;
            active_d = 1'b0;
            cd_d     = '0;
            state_d  = ST_COOLDOWN;
          end else begin
            ypos_d = ypos_q - 1'b1;
          end
        end
      end

      ST_COOLDOWN: begin
        if (cd_q == CD_LAST) begin
          cd_d    = '0;
          state_d = ST_IDLE;
        end else begin
          cd_d = cd_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  // State, position and pulse registers; all outputs come straight from here.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (!rst) begin
      state_q  <= ST_IDLE;
      xpos_q   <= '0;
      ypos_q   <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      done_q   <= 1'b0;
      cd_q     <= '0;
      // Held high through reset so a button pressed at release does not fire.
      up_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      active_q <= active_d;
      hit_q    <= hit_d;
      done_q   <= done_d;
      cd_q     <= cd_d;
      up_q     <= up;
    end
  end

  assign xpos_bullet   = xpos_q;
  assign ypos_bullet   = ypos_q;
  assign bullet_active = active_q;
  assign bullet_hit    = hit_q;
  assign bullet_done   = done_q;

endmodule

// File: tb/tb_tank_bullet.sv
// Self-checking bench for tank_bullet: directed scenarios plus random play,
// compared every cycle against a timing-formula model of the bullet.
module tb_tank_bullet;

  localparam int STEP_DIV     = 4;
  localparam int Y_TOP        = 30;
  localparam int COOLDOWN_CYC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up  = 1'b1;
  logic       hit = 1'b0;
  logic [9:0] xpos_tank = '0;
  logic [9:0] ypos_tank = '0;
  logic [9:0] xpos_bullet;
  logic [9:0] ypos_bullet;
  logic       bullet_active;
  logic       bullet_hit;
  logic       bullet_done;

  tank_bullet #(
    .STEP_DIV     (STEP_DIV),
    .Y_TOP        (Y_TOP),
    .COOLDOWN_CYC (COOLDOWN_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .up            (up),
    .xpos_tank     (xpos_tank),
    .ypos_tank     (ypos_tank),
    .hit           (hit),
    .xpos_bullet   (xpos_bullet),
    .ypos_bullet   (ypos_bullet),
    .bullet_active (bullet_active),
    .bullet_hit    (bullet_hit),
    .bullet_done   (bullet_done)
  );

  always #5 clk = ~clk;

  // Reference model: the bullet is described by its launch cycle and start
  // point; position and retirement follow from elapsed time.
  typedef enum {M_IDLE, M_FLY, M_COOL} mphase_t;

  mphase_t m_phase = M_IDLE;
  int      m_k = 0, m_t = 0, m_x = 0, m_y0 = 0, m_yf = 0;
  bit      m_up_prev = 1'b1;
  bit      m_hit_pulse = 1'b0, m_done_pulse = 1'b0;
  int      m_launches = 0;
  int      obs_launches = 0;
  bit      prev_active = 1'b0;
  int      cyc = 0;
  int      n_assert = 0;
  int      n_fail = 0;

  function automatic int m_climb_steps();
    return (m_y0 > Y_TOP) ? (m_y0 - Y_TOP) : 0;
  endfunction

  // Height after edge e when nothing has stopped the bullet: one pixel per
  // STEP_DIV cycles since launch, never above the top row.
  function automatic int m_pos(int e);
    int n;
    int s;
    n = (e - m_k) / STEP_DIV;
    s = m_climb_steps();
    return m_y0 - ((n < s) ? n : s);
  endfunction

  task automatic model_reset();
    m_phase      = M_IDLE;
    m_x          = 0;
    m_yf         = 0;
    m_up_prev    = 1'b1;
    m_hit_pulse  = 1'b0;
    m_done_pulse = 1'b0;
  endtask

  task automatic model_edge();
    bit fire;
    fire = up & ~m_up_prev;
    m_hit_pulse  = 1'b0;
    m_done_pulse = 1'b0;
    case (m_phase)
      M_IDLE: begin
        if (fire) begin
          m_phase = M_FLY;
          m_k     = cyc;
          m_x     = int'(xpos_tank);
          m_y0    = int'(ypos_tank);
          m_launches++;
        end
      end
      M_FLY: begin
        if (hit) begin
          m_yf        = m_pos(cyc - 1);
          m_hit_pulse = 1'b1;
          m_phase     = M_COOL;
          m_t         = cyc;
        end else if ((cyc - m_k) / STEP_DIV == m_climb_steps() + 1) begin
          m_yf         = m_pos(cyc);
          m_done_pulse = 1'b1;
          m_phase      = M_COOL;
          m_t          = cyc;
        end
      end
      M_COOL: begin
        if (cyc == m_t + COOLDOWN_CYC) m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
    m_up_prev = up;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic compare_all();
    check("active", 32'(bullet_active), 32'(m_phase == M_FLY));
    check("xpos",   32'(xpos_bullet),   m_x);
    check("ypos",   32'(ypos_bullet),   (m_phase == M_FLY) ? m_pos(cyc) : m_yf);
    check("hit_pulse",  32'(bullet_hit),  32'(m_hit_pulse));
    check("done_pulse", 32'(bullet_done), 32'(m_done_pulse));
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst) model_reset();
    else      model_edge();
    #1;
    compare_all();
    if (bullet_active && !prev_active) obs_launches++;
    prev_active = bullet_active;
  endtask

  task automatic launch(input int x, input int y);
    xpos_tank = 10'(x);
    ypos_tank = 10'(y);
    up = 1'b0;
    step();
    up = 1'b1;
    step();
    up = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (m_phase != M_IDLE && g < 5000) begin
      step();
      g++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with the fire button held through release.
    #1;
    rst = 1'b0;
    #1;
    check("rst_active", 32'(bullet_active), 0);
    check("rst_x",      32'(xpos_bullet),   0);
    check("rst_y",      32'(ypos_bullet),   0);
    check("rst_hit",    32'(bullet_hit),    0);
    check("rst_done",   32'(bullet_done),   0);
    model_reset();
    repeat (3) step();
    rst = 1'b1;
    repeat (10) step();
    check("held_up_no_launch", 32'(bullet_active), 0);

    // Launch and full climb with up held for 100 cycles, then stray presses
    // and tank motion during flight and cooldown.
    xpos_tank = 10'd450;
    ypos_tank = 10'd450;
    up = 1'b0;
    step();
    up = 1'b1;
    step();
    check("launch_active", 32'(bullet_active), 1);
    check("launch_x",      32'(xpos_bullet),   450);
    check("launch_y",      32'(ypos_bullet),   450);
    repeat (3) step();
    step();
    check("first_step_y", 32'(ypos_bullet), 449);
    repeat (95) step();
    while (m_phase != M_IDLE && cyc < 4000) begin
      up        = ($urandom_range(0, 29) == 0);
      xpos_tank = 10'($urandom_range(0, 1023));
      step();
    end
    check("one_launch", obs_launches, 1);
    check("x_fixed",    32'(xpos_bullet), 450);
    check("top_final_y", 32'(ypos_bullet), Y_TOP);

    // Relaunch after cooldown from a tank already at or above the top row.
    launch(600, 20);
    check("relaunch_x", 32'(xpos_bullet), 600);
    repeat (3) step();
    step();
    check("top_done_first_tick", 32'(bullet_done), 1);
    wait_idle();

    // Hit on the same edge as a climb step at y=440.
    launch(300, 450);
    repeat (43) step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("hit_y_frozen", 32'(ypos_bullet),   440);
    check("hit_pulse_on", 32'(bullet_hit),    1);
    check("hit_no_done",  32'(bullet_done),   0);
    check("hit_inactive", 32'(bullet_active), 0);
    step();
    check("hit_pulse_off", 32'(bullet_hit), 0);
    hit = 1'b1;
    repeat (3) step();
    hit = 1'b0;
    wait_idle();

    // Random play.
    repeat (3000) begin
      up        = ($urandom_range(0, 3) == 0);
      hit       = ($urandom_range(0, 39) == 0);
      xpos_tank = 10'($urandom_range(0, 1023));
      ypos_tank = 10'($urandom_range(5, 90));
      step();
    end
    up  = 1'b0;
    hit = 1'b0;
    wait_idle();

    // Reset during flight clears everything at once, without pulses.
    launch(200, 400);
    repeat (57) step();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_active", 32'(bullet_active), 0);
    check("midrst_x",      32'(xpos_bullet),   0);
    check("midrst_y",      32'(ypos_bullet),   0);
    check("midrst_hit",    32'(bullet_hit),    0);
    check("midrst_done",   32'(bullet_done),   0);
    model_reset();
    prev_active = 1'b0;
    up = 1'b1;
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
    up = 1'b0;
    step();

    check("launch_count", obs_launches, m_launches);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
